// File: rtl/mii_rx_sched.sv
`timescale 1ns/1ps
// mii_rx_sched
// Rate-adapting scheduler placed in front of mii_io_rx. Receive nibbles arrive from
// the PCS on an irregular strobe (in_ce). They are queued in a small FIFO and replayed
// on a fixed cadence of one nibble every CE_DIV clocks. Each frame is preloaded before
// it is released, which absorbs jitter between the two rates. Running dry mid-frame
// (underflow) or losing a nibble to a full FIFO (overflow) corrupts the frame through err.
//
// Strobe semantics: there is no back-pressure anywhere. in_valid/in_err/in_data are
// sampled only in cycles where in_ce is high. valid/err/data change only on the edge
// that raises ce, so a consumer samples them whenever ce is high.
//
// Ports
//   clk        system clock; all logic on posedge
//   rst        synchronous, active-high reset
//   in_ce      PCS nibble strobe
//   in_valid   PCS frame valid (sampled on in_ce)
//   in_err     PCS receive error for this nibble (sampled on in_ce)
//   in_data    PCS nibble (sampled on in_ce)
//   ce         one-clk strobe every CE_DIV clocks
//   valid      frame valid toward mii_io_rx
//   err        receive error toward mii_io_rx
//   data       nibble toward mii_io_rx
//   overflow   one-clk pulse: a write was dropped because the FIFO was full
//   underflow  one-clk pulse: FIFO empty at a send tick in the middle of a frame
//   level      current FIFO occupancy
//   state      scheduler state (0 IDLE, 1 FILL, 2 SEND, 3 ABORT)
module mii_rx_sched #(
    parameter int CE_DIV     = 5,
    parameter int DEPTH_LOG2 = 3,
    parameter int PRELOAD    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_ce,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [3:0]            in_data,
    output logic                  ce,
    output logic                  valid,
    output logic                  err,
    output logic [3:0]            data,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   level,
    output logic [1:0]            state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(CE_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST      = CNT_W'(CE_DIV - 1);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PRELOAD_LEVEL = (DEPTH_LOG2 + 1)'(PRELOAD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    // FIFO entry layout: [5] eof, [4] err, [3:0] data
    logic [5:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] newest;
    logic [CNT_W-1:0]      cnt;

    logic       stg_valid;
    logic       stg_err;
    logic [3:0] stg_data;
    logic       corrupt;

    logic       tick;
    logic       empty;
    logic       full;
    logic       any_eof;
    logic       wr_req;
    logic       wr_eof;
    logic       do_write;
    logic       drop;
    logic       pop;
    logic [5:0] head;
    logic [5:0] wr_entry;

    assign tick     = (cnt == CNT_LAST);
    assign empty    = (level == '0);
    assign full     = (level == FULL_LEVEL);
    assign head     = mem[rd_ptr];
    assign newest   = wr_ptr - 1'b1;

    // The staged nibble is committed on the next strobe; that strobe's in_valid tells
    // whether the staged nibble was the last of its frame.
    assign wr_req   = in_ce && stg_valid;
    assign wr_eof   = !in_valid;
    assign wr_entry = {wr_eof, stg_err | corrupt, stg_data};
    // Fullness is judged on the pre-pop count, so a same-cycle pop never makes room.
    assign do_write = wr_req && !full;
    assign drop     = wr_req && full;

    // A short frame may be entirely queued before PRELOAD is reached; any queued eof
    // releases it. Only slots inside the occupied window count.
    always_comb begin
        any_eof = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i][5] && ({1'b0, DEPTH_LOG2'(i) - rd_ptr} < level)) begin
                any_eof = 1'b1;
            end
        end
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            S_FILL:  pop = tick && ((level >= PRELOAD_LEVEL) || any_eof);
            S_SEND:  pop = tick && !empty;
            S_ABORT: pop = tick && !empty;
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage. When an eof entry is dropped, the newest stored nibble is turned
    // into an errored eof so the frame still terminates downstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_write) begin
                mem[wr_ptr] <= wr_entry;
            end else if (drop && wr_eof) begin
                mem[newest] <= {2'b11, mem[newest][3:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ce        <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            data      <= 4'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            level     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            stg_valid <= 1'b0;
            stg_err   <= 1'b0;
            stg_data  <= 4'h0;
            corrupt   <= 1'b0;
            state     <= S_IDLE;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            ce        <= tick;
            overflow  <= drop;
            underflow <= 1'b0;

            if (in_ce) begin
                stg_valid <= in_valid;
                stg_err   <= in_err;
                stg_data  <= in_data;
            end

            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_eof) begin
                    corrupt <= 1'b0;
                end
            end
            // A dropped mid-frame nibble poisons the rest of the frame; a dropped eof
            // is folded into the newest entry, which ends the frame.
            if (drop) begin
                corrupt <= !wr_eof;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({do_write, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (tick) begin
                case (state)
                    S_IDLE: begin
                        valid <= 1'b0;
                        err   <= 1'b0;
                        data  <= 4'h0;
                        if (!empty) begin
                            state <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (pop) begin
                            valid <= 1'b1;
                            err   <= head[4];
                            data  <= head[3:0];
                            state <= head[5] ? S_IDLE : S_SEND;
                        end else begin
                            valid <= 1'b0;
                            err   <= 1'b0;
                            data  <= 4'h0;
                        end
                    end
                    S_SEND: begin
                        if (empty) begin
                            valid     <= 1'b1;
                            err       <= 1'b1;
                            data      <= 4'h0;
                            underflow <= 1'b1;
                            state     <= S_ABORT;
                        end else begin
                            valid <= 1'b1;
                            err   <= head[4];
                            data  <= head[3:0];
                            if (head[5]) begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        // ABORT: keep the frame marked bad and flush it up to its eof.
                        valid <= 1'b1;
                        err   <= 1'b1;
                        data  <= 4'h0;
                        if (!empty && head[5]) begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mii_rx_sched.sv
`timescale 1ns/1ps
// Bench for mii_rx_sched: directed scenarios plus randomized frames, every cycle compared
// against a queue-based behavioural model of the scheduler.
module tb_mii_rx_sched;

  localparam int CE_DIV     = 5;
  localparam int DEPTH_LOG2 = 3;
  localparam int PRELOAD    = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_ce = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_err = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       ce, valid, err, overflow, underflow;
  logic [3:0] data;
  logic [DEPTH_LOG2:0] level;
  logic [1:0] state;

  always #5 clk = ~clk;

  mii_rx_sched #(.CE_DIV(CE_DIV), .DEPTH_LOG2(DEPTH_LOG2), .PRELOAD(PRELOAD)) dut (
    .clk(clk), .rst(rst), .in_ce(in_ce), .in_valid(in_valid), .in_err(in_err),
    .in_data(in_data), .ce(ce), .valid(valid), .err(err), .data(data),
    .overflow(overflow), .underflow(underflow), .level(level), .state(state)
  );

  // bookkeeping
  int errors = 0;
  int checks = 0;
  int cycle_no = 0;
  int first_ce = 0;
  int ce_cnt = 0;
  int ovf_cnt = 0;
  int unf_cnt = 0;
  logic [4:0] exp_q[$];   // expected {err,data} per output nibble of a directed frame
  logic [4:0] got_q[$];   // {err,data} seen on ce while valid

  // behavioural model: FIFO as a queue of {eof,err,data}
  logic [5:0] m_fifo[$];
  int         m_cnt;
  int         m_phase;   // 0 waiting, 1 filling, 2 sending, 3 aborting
  bit         m_ce, m_valid, m_err, m_ovf, m_unf;
  logic [3:0] m_data;
  bit         st_full, st_err, m_corrupt;
  logic [3:0] st_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle_no, obs, expv);
    end
  endtask

  function automatic void model_update(bit r, bit c, bit v, bit e, logic [3:0] d);
    int lvl;
    bit tick, has_eof, take;
    logic [5:0] hd, w, t;
    if (r) begin
      m_fifo.delete();
      m_cnt = 0; m_phase = 0;
      m_ce = 0; m_valid = 0; m_err = 0; m_data = 4'h0; m_ovf = 0; m_unf = 0;
      st_full = 0; st_err = 0; st_data = 4'h0; m_corrupt = 0;
      return;
    end
    lvl  = m_fifo.size();
    tick = (m_cnt == CE_DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_ce = tick; m_ovf = 0; m_unf = 0;
    has_eof = 0;
    foreach (m_fifo[i]) if (m_fifo[i][5]) has_eof = 1;
    hd = (lvl > 0) ? m_fifo[0] : 6'h0;
    take = 0;
    if (tick) begin
      if (m_phase == 0) begin
        m_valid = 0; m_err = 0; m_data = 4'h0;
        if (lvl > 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (lvl >= PRELOAD || has_eof) begin
          take = 1; m_valid = 1; m_err = hd[4]; m_data = hd[3:0];
          m_phase = hd[5] ? 0 : 2;
        end else begin
          m_valid = 0; m_err = 0; m_data = 4'h0;
        end
      end else if (m_phase == 2) begin
        if (lvl == 0) begin
          m_valid = 1; m_err = 1; m_data = 4'h0; m_unf = 1; m_phase = 3;
        end else begin
          take = 1; m_valid = 1; m_err = hd[4]; m_data = hd[3:0];
          if (hd[5]) m_phase = 0;
        end
      end else begin
        m_valid = 1; m_err = 1; m_data = 4'h0;
        if (lvl > 0) begin
          take = 1;
          if (hd[5]) m_phase = 0;
        end
      end
    end
    if (c) begin
      if (st_full) begin
        w = {!v, st_err | m_corrupt, st_data};
        if (lvl == DEPTH) begin
          m_ovf = 1;
          if (!v) begin
            t = m_fifo[lvl - 1];
            t[5:4] = 2'b11;
            m_fifo[lvl - 1] = t;
            m_corrupt = 0;
          end else begin
            m_corrupt = 1;
          end
        end else begin
          m_fifo.push_back(w);
          if (!v) m_corrupt = 0;
        end
      end
      st_full = v; st_err = e; st_data = d;
    end
    if (take) void'(m_fifo.pop_front());
  endfunction

  // driver: apply one cycle of inputs, advance model, compare all outputs
  task automatic step(input bit r, input bit c, input bit v, input bit e, input logic [3:0] d);
    logic [12:0] dv, mv;
    rst = r; in_ce = c; in_valid = v; in_err = e; in_data = d;
    @(posedge clk);
    model_update(r, c, v, e, d);
    #1;
    cycle_no++;
    dv = {ce, valid, err, data, overflow, underflow, level};
    mv = {m_ce, m_valid, m_err, m_data, m_ovf, m_unf, 4'(m_fifo.size())};
    check("cycle_outputs", 32'(dv), 32'(mv));
    if (!r) begin
      if (ce) begin
        ce_cnt++;
        if (first_ce == 0) first_ce = cycle_no;
      end
      if (ce && valid) got_q.push_back({err, data});
      if (overflow) ovf_cnt++;
      if (underflow) unf_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0);
  endtask

  task automatic frame(input int n, input int gap_lo, input int gap_hi, input bit rnd,
                       input logic [3:0] base);
    logic [3:0] d;
    bit e;
    int g;
    exp_q.delete();
    got_q.delete();
    ovf_cnt = 0;
    unf_cnt = 0;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 4'($urandom_range(0, 15)) : base + 4'(i);
      e = rnd && ($urandom_range(0, 9) == 0);
      exp_q.push_back({e, d});
      step(0, 1, 1, e, d);
      g = $urandom_range(gap_lo, gap_hi);
      for (int k = 1; k < g; k++) step(0, 0, 0, 0, 4'h0);
    end
    step(0, 1, 0, 0, 4'h0);
    for (int k = 1; k < gap_lo; k++) step(0, 0, 0, 0, 4'h0);
  endtask

  task automatic compare_frame(input string tag);
    int n;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and idle cadence
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'h0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    cycle_no = 0; first_ce = 0; ce_cnt = 0;
    idle(15);
    check("t1_first_ce", 32'(first_ce), 32'(CE_DIV));
    check("t1_ce_count", 32'(ce_cnt), 32'd3);

    // 2: 16 nibbles 0..F at the output rate
    frame(16, 5, 5, 0, 4'h0);
    idle(60);
    compare_frame("t2_data");
    check("t2_overflow", 32'(ovf_cnt), 32'd0);
    check("t2_underflow", 32'(unf_cnt), 32'd0);
    check("t2_level", 32'(level), 32'd0);
    check("t2_valid_end", 32'(valid), 32'd0);

    // 3: input slower than output -> one underflow, frame aborted with err
    frame(40, 6, 6, 0, 4'h0);
    idle(80);
    check("t3_underflow", 32'(unf_cnt), 32'd1);
    check("t3_state_idle", 32'(state), 32'd0);
    check("t3_valid_end", 32'(valid), 32'd0);
    check("t3_tail_err", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1][4]) : 32'd0, 32'd1);

    // 4: back-to-back burst overflows the FIFO; frame still terminates
    frame(12, 1, 1, 0, 4'h0);
    idle(100);
    check("t4_overflow_seen", 32'(ovf_cnt != 0), 32'd1);
    check("t4_tail_err", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1][4]) : 32'd0, 32'd1);
    check("t4_valid_end", 32'(valid), 32'd0);
    frame(6, 5, 5, 0, 4'h3);
    idle(60);
    compare_frame("t4_clean");

    // 5: frame shorter than the preload
    frame(3, 5, 5, 0, 4'hA);
    idle(60);
    compare_frame("t5_short");

    // 6: reset in the middle of sending
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 4'(i));
      idle(4);
    end
    check("t6_sending", 32'(valid), 32'd1);
    step(1, 0, 0, 0, 4'h0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_ce", 32'(ce), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    idle(10);
    frame(8, 5, 5, 0, 4'h5);
    idle(60);
    compare_frame("t6_after");

    // randomized frames: jittered strobe, random lengths, occasional PCS errors
    for (int f = 0; f < 12; f++) begin
      frame($urandom_range(1, 24), 1, 8, 1, 4'h0);
      idle($urandom_range(0, 40));
    end
    idle(150);
    check("rand_level_end", 32'(level), 32'd0);
    check("rand_valid_end", 32'(valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
